osd_pingpong_renderer: RTL and testbench

//  Parametrised display-list OSD renderer. Walks a 64-bit instruction list once per

---
 rtl/osd_pkg.sv | 24 ++
 rtl/osd_line_buffer.sv | 31 +++
 rtl/osd_pingpong_renderer.sv | 164 ++++++++++++++++
 tb/tb_osd_pingpong_renderer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared definitions for the OSD ping-pong renderer: opcodes, instruction
// layout and render FSM encoding.
package osd_pkg;

  localparam int CW = 12;

  localparam logic [3:0] OP_RECT = 4'd0;
  localparam logic [3:0] OP_END  = 4'd1;

  // Low 56 bits of an instruction word; bits [63:56] are reserved.
  typedef struct packed {
    logic [CW-1:0] x1;
    logic [CW-1:0] x0;
    logic [3:0]    op;
    logic [3:0]    idx;
    logic [CW-1:0] y1;
    logic [CW-1:0] y0;
  } inst_t;

  typedef enum logic [2:0] {
    R_IDLE, R_CLEAR, R_FETCH, R_DECODE, R_DRAW, R_DONE
  } rstate_e;

endpackage

// File: rtl/osd_line_buffer.sv
// Dual-bank line RAM: the renderer writes the back bank while the stream side
// reads the front bank through a registered read port.
module osd_line_buffer
  import osd_pkg::*;
#(
  parameter int PIX_W    = 16,
  parameter int H_ACTIVE = 320,
  parameter int AW       = 9
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             bank_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem [2][H_ACTIVE];

  always_ff @(posedge hclk) begin
    if (we_i) mem[~bank_i][waddr_i] <= wdata_i;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) rdata_o <= '0;
    else          rdata_o <= mem[bank_i][raddr_i];
  end

endmodule

// File: rtl/osd_pingpong_renderer.sv
// Display-list OSD renderer: paints rectangles into a back line buffer and streams
// the front buffer as AXI4-Stream. OSD_TRANSPARENT_EN makes palette index 0 transparent.
module osd_pingpong_renderer
  import osd_pkg::*;
#(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int PIX_W      = 16,
  parameter int INST_DEPTH = 256
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic                          en,
  input  logic [PIX_W-1:0]              bg_color,
  input  logic                          inst_we,
  input  logic [$clog2(INST_DEPTH)-1:0] inst_waddr,
  input  logic [63:0]                   inst_wdata,
  input  logic                          pal_we,
  input  logic [3:0]                    pal_waddr,
  input  logic [PIX_W-1:0]              pal_wdata,
  output logic                          busy,
  output logic [PIX_W-1:0]              tdata_m,
  output logic                          tvalid_m,
  input  logic                          tready_m,
  output logic                          tlast_m,
  output logic                          tuser_m
);

  localparam int PCW = $clog2(INST_DEPTH);
  localparam int AW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [CW-1:0]  H_MAX   = CW'(H_ACTIVE);
  localparam logic [CW-1:0]  H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  V_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(INST_DEPTH - 1);

  logic [55:0]      imem [INST_DEPTH];
  logic [PIX_W-1:0] pal  [16];
  inst_t            inst_q;
  logic             unused_hi;

  rstate_e          st_q, st_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [CW-1:0]    x_q, x_d, xend_q, xend_d, y_q, y_d, rptr_q, rptr_d;
  logic [PIX_W-1:0] col_q, col_d, lb_wdata, lb_rdata;
  logic             skip_q, skip_d, bank_q, bank_d, fv_q, fv_d;
  logic             sof_q, sof_d, eof_q, eof_d, busy_q, busy_d, tv_q, tv_d;
  logic             lb_we, hit, hs;

  assign unused_hi = ^inst_wdata[63:56];

  // Writes land immediately; a same-cycle read of the same entry sees old data.
  always_ff @(posedge hclk) begin
    if (inst_we) imem[inst_waddr] <= inst_wdata[55:0];
    if (pal_we)  pal[pal_waddr]   <= pal_wdata;
    if (st_q == R_FETCH) inst_q <= imem[pc_q];
  end

  assign hit = (inst_q.op == OP_RECT) && (inst_q.y0 <= y_q) && (y_q < inst_q.y1) &&
               (inst_q.x0 < inst_q.x1) && (inst_q.x0 < H_MAX);
  assign hs  = tv_q && tready_m;

  always_comb begin
    st_d = st_q;   pc_d = pc_q;     x_d = x_q;     xend_d = xend_q; y_d = y_q;
    col_d = col_q; skip_d = skip_q; bank_d = bank_q; fv_d = fv_q;
    sof_d = sof_q; eof_d = eof_q;   busy_d = busy_q; tv_d = tv_q; rptr_d = rptr_q;
    lb_we = 1'b0;  lb_wdata = bg_color;

    // Stream side: rptr_d doubles as the read address so the RAM output is
    // always the pixel being presented, and stays put during a stall.
    if (hs) begin
      if (rptr_q == H_LAST) begin
        tv_d = 1'b0; rptr_d = '0; fv_d = 1'b0;
        if (eof_q && st_q == R_IDLE) busy_d = 1'b0;
      end else begin
        rptr_d = rptr_q + 12'd1;
      end
    end else if (!tv_q && fv_q) begin
      tv_d = 1'b1;
    end

    case (st_q)
      R_IDLE: if (en) begin
        st_d = R_CLEAR; busy_d = 1'b1; x_d = '0;
      end
      R_CLEAR: begin
        lb_we = 1'b1;
        x_d   = x_q + 12'd1;
        if (x_q == H_LAST) st_d = R_FETCH;
      end
      R_FETCH: st_d = R_DECODE;
      R_DECODE: begin
        if (inst_q.op == OP_END) begin
          st_d = R_DONE;
        end else if (hit) begin
          st_d   = R_DRAW;
          x_d    = inst_q.x0;
          xend_d = (inst_q.x1 > H_MAX) ? H_MAX : inst_q.x1;
          col_d  = pal[inst_q.idx];
`ifdef OSD_TRANSPARENT_EN
          skip_d = (inst_q.idx == 4'd0);
`else
          skip_d = 1'b0;
`endif
        end else if (pc_q == PC_LAST) begin
          st_d = R_DONE;
        end else begin
          pc_d = pc_q + 1'b1; st_d = R_FETCH;
        end
      end
      R_DRAW: begin
        lb_we    = !skip_q;
        lb_wdata = col_q;
        x_d      = x_q + 12'd1;
        if (x_q == xend_q - 12'd1) begin
          if (pc_q == PC_LAST) st_d = R_DONE;
          else begin pc_d = pc_q + 1'b1; st_d = R_FETCH; end
        end
      end
      R_DONE: if (!fv_q) begin
        bank_d = ~bank_q; fv_d = 1'b1; pc_d = '0; x_d = '0;
        sof_d  = (y_q == '0);
        eof_d  = (y_q == V_LAST);
        if (y_q == V_LAST) begin
          y_d  = '0;
          st_d = en ? R_CLEAR : R_IDLE;
        end else begin
          y_d  = y_q + 12'd1;
          st_d = R_CLEAR;
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st_q <= R_IDLE; pc_q <= '0; x_q <= '0; xend_q <= '0; y_q <= '0;
      col_q <= '0; skip_q <= 1'b0; bank_q <= 1'b0; fv_q <= 1'b0;
      sof_q <= 1'b0; eof_q <= 1'b0; busy_q <= 1'b0; tv_q <= 1'b0; rptr_q <= '0;
    end else begin
      st_q <= st_d; pc_q <= pc_d; x_q <= x_d; xend_q <= xend_d; y_q <= y_d;
      col_q <= col_d; skip_q <= skip_d; bank_q <= bank_d; fv_q <= fv_d;
      sof_q <= sof_d; eof_q <= eof_d; busy_q <= busy_d; tv_q <= tv_d; rptr_q <= rptr_d;
    end
  end

  osd_line_buffer #(.PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .AW(AW)) u_lbuf (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bank_i  (bank_q),
    .we_i    (lb_we),
    .waddr_i (x_q[AW-1:0]),
    .wdata_i (lb_wdata),
    .raddr_i (rptr_d[AW-1:0]),
    .rdata_o (lb_rdata)
  );

  assign busy     = busy_q;
  assign tdata_m  = lb_rdata;
  assign tvalid_m = tv_q;
  assign tlast_m  = tv_q && (rptr_q == H_LAST);
  assign tuser_m  = tv_q && (rptr_q == '0) && sof_q;

endmodule

// File: tb/tb_osd_pingpong_renderer.sv
// Directed scoreboard bench for osd_pingpong_renderer (H=8, V=4, 16-entry list).
module tb_osd_pingpong_renderer;
  localparam int H = 8, V = 4, PW = 16, D = 16;

  logic          hclk = 0, hresetn = 0, en = 0;
  logic [PW-1:0] bg_color = '0;
  logic          inst_we = 0, pal_we = 0;
  logic [3:0]    inst_waddr = '0, pal_waddr = '0;
  logic [63:0]   inst_wdata = '0;
  logic [PW-1:0] pal_wdata = '0;
  logic          busy, tvalid_m, tlast_m, tuser_m;
  logic          tready_m = 0;
  logic [PW-1:0] tdata_m;

  int ncmp = 0, nfail = 0, cyc = 0, tlast_cnt = 0;
  logic [63:0]   tb_inst [D];
  logic [PW-1:0] tb_pal  [16];
  logic [17:0]   q[$];
  logic [17:0]   held;
  bit            stall = 0;

  always #5 hclk = ~hclk;

  osd_pingpong_renderer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .INST_DEPTH(D)) dut (
    .hclk(hclk), .hresetn(hresetn), .en(en), .bg_color(bg_color),
    .inst_we(inst_we), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .busy(busy), .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
    .tlast_m(tlast_m), .tuser_m(tuser_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [11:0] y0, y1, x0, x1,
                                     input logic [3:0] idx);
    return {8'h00, x1, x0, op, idx, y1, y0};
  endfunction

  // Reference: walk the list in order, later rectangles overwrite earlier ones.
  function automatic logic [PW-1:0] model_pix(input int y, input int x);
    logic [PW-1:0] c;
    logic [63:0] w;
    c = bg_color;
    for (int p = 0; p < D; p++) begin
      w = tb_inst[p];
      if (w[31:28] == 4'd1) break;
      if (w[31:28] == 4'd0 && int'(w[11:0]) <= y && y < int'(w[23:12]) &&
          x >= int'(w[43:32]) && x < int'(w[55:44]) && x < H) begin
`ifdef OSD_TRANSPARENT_EN
        if (w[27:24] != 4'd0) c = tb_pal[w[27:24]];
`else
        c = tb_pal[w[27:24]];
`endif
      end
    end
    return c;
  endfunction

  always @(negedge hclk) if (hresetn) begin
    if (stall) begin
      chk("stall_valid", {31'b0, tvalid_m}, 32'd1);
      chk("stall_data", {14'b0, tuser_m, tlast_m, tdata_m}, {14'b0, held});
    end
    if (tvalid_m && tready_m) begin
      if (q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
      else chk("beat", {14'b0, tuser_m, tlast_m, tdata_m}, {14'b0, q.pop_front()});
      if (tlast_m) tlast_cnt++;
    end
    stall = tvalid_m && !tready_m;
    held  = {tuser_m, tlast_m, tdata_m};
  end

  task automatic tick();
    @(posedge hclk); #1;
  endtask

  task automatic step(input bit slow);
    tick();
    cyc++;
    tready_m = !slow || (cyc % 3 == 0);
  endtask

  task automatic wr_inst(input int a, input logic [63:0] w);
    inst_we = 1; inst_waddr = 4'(a); inst_wdata = w; tb_inst[a] = w;
    tick(); inst_we = 0;
  endtask

  task automatic wr_pal(input int a, input logic [PW-1:0] c);
    pal_we = 1; pal_waddr = 4'(a); pal_wdata = c; tb_pal[a] = c;
    tick(); pal_we = 0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < D; i++) wr_inst(i, mk(4'd2, 12'd0, 12'd4095, 12'd0, 12'd8, 4'd1));
  endtask

  task automatic push_frame();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        q.push_back({(x == 0 && y == 0), (x == H - 1), model_pix(y, x)});
  endtask

  // Start a frame, keep en high until `hold` lines have streamed, then let it drain.
  task automatic run_frame(input bit slow, input int hold);
    int n, base;
    base = tlast_cnt;
    en = 1;
    step(slow);
    n = 0;
    while (tlast_cnt < base + hold && n < 2000) begin step(slow); n++; end
    en = 0;
    step(slow);
    chk("busy_run", {31'b0, busy}, 32'd1);
    n = 0;
    while ((busy || q.size() != 0) && n < 5000) begin step(slow); n++; end
    chk("no_timeout", {31'b0, n < 5000}, 32'd1);
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("q_empty", q.size(), 32'd0);
    chk("line_count", tlast_cnt - base, V);
    for (int i = 0; i < 20; i++) begin
      step(slow);
      chk("idle_tvalid", {31'b0, tvalid_m}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy",   {31'b0, busy},     32'd0);
    chk("rst_tvalid", {31'b0, tvalid_m}, 32'd0);
    chk("rst_tlast",  {31'b0, tlast_m},  32'd0);
    chk("rst_tuser",  {31'b0, tuser_m},  32'd0);
    chk("rst_tdata",  {16'b0, tdata_m},  32'd0);
    hresetn = 1;
    tick();

    // Empty list: background only
    bg_color = 16'h1234;
    fill_nop();
    wr_inst(0, mk(4'd1, 12'd0, 12'd0, 12'd0, 12'd0, 4'd0));
    push_frame();
    run_frame(1'b0, 0);

    // One rectangle on lines 1..2, consumer throttled to 1/3 duty
    wr_pal(3, 16'hF800);
    wr_inst(0, mk(4'd0, 12'd1, 12'd3, 12'd2, 12'd5, 4'd3));
    wr_inst(1, mk(4'd1, 12'd0, 12'd0, 12'd0, 12'd0, 4'd0));
    push_frame();
    run_frame(1'b1, 0);

    // Rectangle clipped at the right edge plus an index-0 rectangle
    bg_color = 16'h0A0A;
    wr_pal(5, 16'h07E0);
    wr_pal(0, 16'h001F);
    wr_inst(0, mk(4'd0, 12'd0, 12'd4095, 12'd6, 12'd100, 4'd5));
    wr_inst(1, mk(4'd0, 12'd2, 12'd4, 12'd0, 12'd1, 4'd0));
    wr_inst(2, mk(4'd7, 12'd0, 12'd4, 12'd0, 12'd8, 4'd3));
    wr_inst(3, mk(4'd1, 12'd0, 12'd0, 12'd0, 12'd0, 4'd0));
    push_frame();
    run_frame(1'b0, 0);

    // No END anywhere; en held through line 0 then dropped during line 1
    bg_color = 16'h5555;
    fill_nop();
    push_frame();
    run_frame(1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
